axi_read_arbiter: RTL and testbench



---
 rtl/axi_arb_pkg.sv | 12 +
 rtl/rr_arbiter_2.sv | 14 +
 rtl/axi_read_arbiter.sv | 117 +++++++++++
 tb/tb_axi_read_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared types for the two-requester AXI read arbiter.
package axi_arb_pkg;
  localparam int ADDR_MAX = 64;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_e;
  typedef enum logic {REQ_I, REQ_D} req_id_e;
  typedef struct packed {
    logic [ADDR_MAX-1:0] addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } ar_req_t;
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin pick; on a tie the requester not granted last wins.
module rr_arbiter_2
  import axi_arb_pkg::*;
(
  input  logic    i_req,
  input  logic    d_req,
  input  req_id_e last_grant,
  output logic    grant_valid,
  output req_id_e grant
);
  assign grant_valid = i_req | d_req;
  assign grant = (i_req && d_req) ? (last_grant == REQ_I ? REQ_D : REQ_I)
               : (i_req ? REQ_I : REQ_D);
endmodule

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI AR/R master port between the I- and D-cache,
// one burst at a time, with round-robin fairness and snoop-stall grant gating.
module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter int addr_width = 64,
  parameter int data_width = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  snoop_stall,
  input  logic                  i_arvalid,
  input  logic [addr_width-1:0] i_araddr,
  input  logic [7:0]            i_arlen,
  input  logic [2:0]            i_arsize,
  input  logic [1:0]            i_arburst,
  output logic                  i_arready,
  output logic                  i_rvalid,
  output logic [data_width-1:0] i_rdata,
  output logic                  i_rlast,
  input  logic                  i_rready,
  input  logic                  d_arvalid,
  input  logic [addr_width-1:0] d_araddr,
  input  logic [7:0]            d_arlen,
  input  logic [2:0]            d_arsize,
  input  logic [1:0]            d_arburst,
  output logic                  d_arready,
  output logic                  d_rvalid,
  output logic [data_width-1:0] d_rdata,
  output logic                  d_rlast,
  input  logic                  d_rready,
  output logic                  m_axi_arvalid,
  output logic [addr_width-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  input  logic                  m_axi_arready,
  input  logic                  m_axi_rvalid,
  input  logic                  m_axi_rlast,
  input  logic [data_width-1:0] m_axi_rdata,
  output logic                  m_axi_rready,
  output logic                  instruction_cache_reading,
  output logic                  data_cache_reading,
  output logic                  burst_err
);
  arb_state_e state;
  req_id_e    owner, last_grant, grant;
  ar_req_t    req, sel;
  logic [7:0] beats;
  logic       grant_valid, accept, i_sel, d_sel, hs;

  rr_arbiter_2 u_rr (
    .i_req      (i_arvalid),
    .d_req      (d_arvalid),
    .last_grant (last_grant),
    .grant_valid(grant_valid),
    .grant      (grant)
  );

  // arready is gated by reset so nothing is accepted while reset is held
  assign accept    = state == IDLE && !snoop_stall && grant_valid && !reset;
  assign i_arready = accept && grant == REQ_I;
  assign d_arready = accept && grant == REQ_D;
  assign sel = grant == REQ_I ? {ADDR_MAX'(i_araddr), i_arlen, i_arsize, i_arburst}
                              : {ADDR_MAX'(d_araddr), d_arlen, d_arsize, d_arburst};

  assign m_axi_arvalid = state == ADDR;
  assign m_axi_araddr  = req.addr[addr_width-1:0];
  assign m_axi_arlen   = req.len;
  assign m_axi_arsize  = req.size;
  assign m_axi_arburst = req.burst;

  assign i_sel        = state == DATA && owner == REQ_I;
  assign d_sel        = state == DATA && owner == REQ_D;
  assign i_rvalid     = i_sel && m_axi_rvalid;
  assign i_rlast      = i_sel && m_axi_rlast;
  assign i_rdata      = i_sel ? m_axi_rdata : '0;
  assign d_rvalid     = d_sel && m_axi_rvalid;
  assign d_rlast      = d_sel && m_axi_rlast;
  assign d_rdata      = d_sel ? m_axi_rdata : '0;
  assign m_axi_rready = (i_sel && i_rready) || (d_sel && d_rready);
  assign hs           = m_axi_rvalid && m_axi_rready;

  assign instruction_cache_reading = state != IDLE && owner == REQ_I;
  assign data_cache_reading        = state != IDLE && owner == REQ_D;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= REQ_I;
      last_grant <= REQ_D;
      req        <= '0;
      beats      <= '0;
      burst_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          req   <= sel;
          owner <= grant;
          beats <= '0;
          state <= ADDR;
        end
        ADDR: if (m_axi_arready) state <= DATA;
        DATA: if (hs) begin
          beats <= beats + 8'd1;
          // early rlast and missing rlast on the final beat both end the burst as errors
          if (m_axi_rlast || beats == req.len) begin
            if (m_axi_rlast != (beats == req.len)) burst_err <= 1'b1;
            last_grant <= owner;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed stimulus with AR/R scoreboards checked by a separate monitor.
module tb_axi_read_arbiter;
  logic clk = 1'b0, reset = 1'b1, snoop_stall = 1'b0;
  logic i_arvalid, i_arready, i_rvalid, i_rlast, i_rready;
  logic d_arvalid, d_arready, d_rvalid, d_rlast, d_rready;
  logic [63:0] i_araddr, d_araddr, i_rdata, d_rdata;
  logic [7:0] i_arlen, d_arlen;
  logic [2:0] i_arsize, d_arsize;
  logic [1:0] i_arburst, d_arburst;
  logic m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rlast, m_axi_rready;
  logic [63:0] m_axi_araddr, m_axi_rdata;
  logic [7:0] m_axi_arlen;
  logic [2:0] m_axi_arsize;
  logic [1:0] m_axi_arburst;
  logic instruction_cache_reading, data_cache_reading, burst_err;
  logic ig, dg;

  typedef struct {logic id; logic last; logic [63:0] data;} r_t;
  typedef struct {logic [63:0] addr; logic [7:0] len;} ar_t;
  typedef struct {int nbeats; int last_idx;} s_t;
  r_t  exp_r[$];
  ar_t exp_ar[$];
  s_t  slv_q[$];
  int  errors = 0, checks = 0;

  always #5 clk = ~clk;

  axi_read_arbiter dut (
    .clk(clk), .reset(reset), .snoop_stall(snoop_stall),
    .i_arvalid(i_arvalid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
    .i_arburst(i_arburst), .i_arready(i_arready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .i_rlast(i_rlast), .i_rready(i_rready),
    .d_arvalid(d_arvalid), .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize),
    .d_arburst(d_arburst), .d_arready(d_arready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .d_rlast(d_rlast), .d_rready(d_rready),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arready(m_axi_arready),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rlast(m_axi_rlast), .m_axi_rdata(m_axi_rdata),
    .m_axi_rready(m_axi_rready),
    .instruction_cache_reading(instruction_cache_reading),
    .data_cache_reading(data_cache_reading), .burst_err(burst_err)
  );

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic expect_burst(input logic id, input logic [63:0] addr, input int len,
                              input int nbeats, input int last_idx);
    exp_ar.push_back('{addr, 8'(len)});
    slv_q.push_back('{nbeats, last_idx});
    for (int b = 0; b < nbeats; b++) exp_r.push_back('{id, b == last_idx, addr + 64'(b)});
  endtask

  task automatic request(input logic id, input logic [63:0] addr, input logic [7:0] len);
    if (!id) begin
      i_arvalid = 1'b1; i_araddr = addr; i_arlen = len; i_arsize = 3'd3; i_arburst = 2'd1;
    end else begin
      d_arvalid = 1'b1; d_araddr = addr; d_arlen = len; d_arsize = 3'd3; d_arburst = 2'd1;
    end
  endtask

  // called at a negedge: remember grants, then drop the granted valids after the edge
  task automatic step();
    ig = i_arready;
    dg = d_arready;
    @(posedge clk);
    #1;
    if (ig) i_arvalid = 1'b0;
    if (dg) d_arvalid = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    step();
  endtask

  task automatic wait_idle(input string name);
    int n;
    logic done;
    done = 1'b0;
    for (n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      done = exp_r.size() == 0 && !i_arvalid && !d_arvalid && !m_axi_rvalid &&
             !instruction_cache_reading && !data_cache_reading;
      step();
    end
    chk({name, "_done"}, done, 1'b1);
  endtask

  task automatic rcheck(input logic id, input logic last, input logic [63:0] data);
    r_t e;
    if (exp_r.size() == 0) chk("r_queue_nonempty", 1'b0, 1'b1);
    else begin
      e = exp_r.pop_front();
      chk(id ? "d_beat" : "i_beat", {id, last, data}, {e.id, e.last, e.data});
    end
  endtask

  // slave model: one-cycle arready, then beats carrying araddr+index
  initial begin
    s_t s;
    logic [63:0] base;
    logic hs, abort;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rdata = '0;
    forever begin
      @(negedge clk);
      if (!reset && m_axi_arvalid && slv_q.size() > 0) begin
        s = slv_q.pop_front();
        base = m_axi_araddr;
        abort = 1'b0;
        @(posedge clk); #1 m_axi_arready = 1'b1;
        @(posedge clk); #1 m_axi_arready = 1'b0;
        for (int b = 0; b < s.nbeats && !abort; b++) begin
          m_axi_rvalid = 1'b1; m_axi_rdata = base + 64'(b); m_axi_rlast = b == s.last_idx;
          hs = 1'b0;
          for (int n = 0; n < 50 && !hs && !reset; n++) begin
            @(negedge clk);
            hs = m_axi_rready && !reset;
          end
          if (!hs) abort = 1'b1;
          else begin
            @(posedge clk); #1;
          end
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rdata = '0;
      end
    end
  end

  initial forever begin
    ar_t a;
    @(negedge clk);
    if (!reset) begin
      if (m_axi_arvalid && m_axi_arready) begin
        if (exp_ar.size() == 0) chk("ar_queue_nonempty", 1'b0, 1'b1);
        else begin
          a = exp_ar.pop_front();
          chk("ar_fields", {m_axi_araddr, m_axi_arlen}, {a.addr, a.len});
        end
      end
      if (i_rvalid && i_rready) rcheck(1'b0, i_rlast, i_rdata);
      if (d_rvalid && d_rready) rcheck(1'b1, d_rlast, d_rdata);
      if (i_rvalid || d_rvalid) chk("r_exclusive", i_rvalid && d_rvalid, 1'b0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    i_arvalid = 1'b1; i_araddr = '0; i_arlen = '0; i_arsize = '0; i_arburst = '0; i_rready = 1'b1;
    d_arvalid = 1'b0; d_araddr = '0; d_arlen = '0; d_arsize = '0; d_arburst = '0; d_rready = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_i_arready", i_arready, 1'b0);
    chk("rst_outputs", {m_axi_arvalid, m_axi_rready, instruction_cache_reading,
                        data_cache_reading, burst_err, m_axi_araddr, m_axi_arlen}, '0);
    i_arvalid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;

    expect_burst(1'b0, 64'h2000, 1, 2, 1);
    expect_burst(1'b1, 64'h3000, 2, 3, 2);
    request(1'b0, 64'h2000, 8'd1);
    request(1'b1, 64'h3000, 8'd2);
    @(negedge clk); chk("tie1_i_wins", {i_arready, d_arready}, 2'b10); step();
    @(negedge clk);
    chk("tie1_addr_phase", {m_axi_arvalid, instruction_cache_reading, data_cache_reading}, 3'b110);
    step();
    wait_idle("tie1");

    expect_burst(1'b0, 64'h1000, 7, 8, 7);
    request(1'b0, 64'h1000, 8'd7);
    @(negedge clk); chk("single_arready", i_arready, 1'b1); step();
    @(negedge clk); chk("single_addr_phase", {m_axi_arvalid, instruction_cache_reading}, 2'b11); step();
    wait_idle("single");

    expect_burst(1'b1, 64'h3100, 0, 1, 0);
    expect_burst(1'b0, 64'h2100, 0, 1, 0);
    request(1'b0, 64'h2100, 8'd0);
    request(1'b1, 64'h3100, 8'd0);
    @(negedge clk); chk("tie2_d_wins", {i_arready, d_arready}, 2'b01); step();
    wait_idle("tie2");

    snoop_stall = 1'b1;
    expect_burst(1'b1, 64'h4000, 3, 4, 3);
    request(1'b1, 64'h4000, 8'd3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); chk("stall_hold", {d_arready, m_axi_arvalid, data_cache_reading}, 3'b000); step();
    end
    snoop_stall = 1'b0;
    @(negedge clk); chk("stall_release", d_arready, 1'b1); step();
    snoop_stall = 1'b1;
    wait_idle("stall_data");
    snoop_stall = 1'b0;
    chk("stall_no_err", burst_err, 1'b0);

    expect_burst(1'b0, 64'h8000, 255, 256, 255);
    request(1'b0, 64'h8000, 8'd255);
    wait_idle("wrap");
    chk("wrap_no_err", burst_err, 1'b0);

    expect_burst(1'b0, 64'h5000, 5, 6, 5);
    request(1'b0, 64'h5000, 8'd5);
    for (n = 0; n < 100 && exp_r.size() > 4; n++) tick();
    i_rready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("bp_rready", {m_axi_rready, i_rvalid}, 2'b01); step();
    end
    i_rready = 1'b1;
    wait_idle("bp");

    expect_burst(1'b1, 64'h6000, 3, 2, 1);
    request(1'b1, 64'h6000, 8'd3);
    wait_idle("err");
    chk("err_set", burst_err, 1'b1);
    expect_burst(1'b0, 64'h7000, 0, 1, 0);
    request(1'b0, 64'h7000, 8'd0);
    wait_idle("err_after");
    chk("err_sticky", burst_err, 1'b1);

    expect_burst(1'b1, 64'h9000, 3, 4, 3);
    request(1'b1, 64'h9000, 8'd3);
    for (n = 0; n < 100 && exp_r.size() > 3; n++) tick();
    #2 reset = 1'b1;
    #1 chk("rst_async", {d_rvalid, d_rlast, d_rdata, m_axi_rready, data_cache_reading,
                         burst_err, m_axi_arvalid, d_arready}, '0);
    exp_r.delete(); exp_ar.delete(); slv_q.delete();
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    expect_burst(1'b1, 64'hA000, 0, 1, 0);
    request(1'b1, 64'hA000, 8'd0);
    @(negedge clk); chk("post_rst_arready", d_arready, 1'b1); step();
    wait_idle("post_rst");
    chk("queues_empty", exp_r.size() + exp_ar.size() + slv_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
